// File: rtl/frame_sequencer.sv
// frame_sequencer: requests frames from a feeder one at a time and counts their bytes.
// Define FRAME_SEQ_LOOP_EN to wrap from LAST_FRAME back to frame 0 instead of stopping in DONE.
module frame_sequencer #(
  parameter int LAST_FRAME  = 124,
  parameter int FRAME_BYTES = 512,
  parameter int GAP_TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       play,
  input  logic       seek_valid,
  input  logic [6:0] seek_frame,
  input  logic       space_ok,
  input  logic       feed_v,
  output logic       frame_num_iv,
  output logic [6:0] frame_num_id,
  output logic [6:0] cur_frame,
  output logic       busy,
  output logic       frame_done,
  output logic       done,
  output logic       timeout_err
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_SPACE = 3'd1,
    S_ISSUE      = 3'd2,
    S_STREAM     = 3'd3,
    S_DONE       = 3'd4
  } state_t;

  localparam logic [6:0]  LAST_ID   = 7'(LAST_FRAME);
  localparam logic [9:0]  BYTES_LIM = 10'(FRAME_BYTES);
  localparam logic [15:0] GAP_LIM   = 16'(GAP_TIMEOUT);

  state_t      state_q, state_d;
  logic [6:0]  cur_frame_q, cur_frame_d;
  logic [6:0]  frame_num_id_q, frame_num_id_d;
  logic [9:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] gap_q, gap_d;
  logic        frame_num_iv_q, frame_num_iv_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        done_q, done_d;
  logic        timeout_err_q, timeout_err_d;

  // Seek targets beyond the last playable frame land on the last frame.
  function automatic logic [6:0] clamp_frame(input logic [6:0] f);
    if (f > LAST_ID) begin
      clamp_frame = LAST_ID;
    end else begin
      clamp_frame = f;
    end
  endfunction

  // State register and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      cur_frame_q    <= 7'd0;
      frame_num_id_q <= 7'd0;
      byte_cnt_q     <= 10'd0;
      gap_q          <= 16'd0;
      frame_num_iv_q <= 1'b0;
      busy_q         <= 1'b0;
      frame_done_q   <= 1'b0;
      done_q         <= 1'b0;
      timeout_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      cur_frame_q    <= cur_frame_d;
      frame_num_id_q <= frame_num_id_d;
      byte_cnt_q     <= byte_cnt_d;
      gap_q          <= gap_d;
      frame_num_iv_q <= frame_num_iv_d;
      busy_q         <= busy_d;
      frame_done_q   <= frame_done_d;
      done_q         <= done_d;
      timeout_err_q  <= timeout_err_d;
    end
  end

  // Next-state logic; outputs are derived from the next state so they align with it.
  always_comb begin
    state_d       = state_q;
    cur_frame_d   = cur_frame_q;
    byte_cnt_d    = byte_cnt_q;
    gap_d         = gap_q;
    frame_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;

    case (state_q)
      S_IDLE: begin
        if (seek_valid) begin
          cur_frame_d = clamp_frame(seek_frame);
        end else begin
          cur_frame_d = cur_frame_q;
        end
        if (play) begin
          state_d = S_WAIT_SPACE;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_WAIT_SPACE: begin
        if (seek_valid) begin
          cur_frame_d = clamp_frame(seek_frame);
        end else begin
          cur_frame_d = cur_frame_q;
        end
        // A seek in the same cycle as space_ok defers the request by a cycle.
        if (!play) begin
          state_d = S_IDLE;
        end else if (!seek_valid && space_ok) begin
          state_d = S_ISSUE;
        end else begin
          state_d = S_WAIT_SPACE;
        end
      end

      S_ISSUE: begin
        state_d    = S_STREAM;
        byte_cnt_d = 10'd0;
        gap_d      = 16'd0;
      end

      S_STREAM: begin
        if (feed_v) begin
          byte_cnt_d = byte_cnt_q + 10'd1;
          gap_d      = 16'd0;
          if (byte_cnt_d == BYTES_LIM) begin
            frame_done_d = 1'b1;
            if (cur_frame_q < LAST_ID) begin
              cur_frame_d = cur_frame_q + 7'd1;
              state_d     = play ? S_WAIT_SPACE : S_IDLE;
            end else begin
`ifdef FRAME_SEQ_LOOP_EN
              cur_frame_d = 7'd0;
              state_d     = play ? S_WAIT_SPACE : S_IDLE;
`else
              cur_frame_d = cur_frame_q;
              state_d     = S_DONE;
`endif
            end
          end else begin
            state_d = S_STREAM;
          end
        end else begin
          // A stalled feeder drops back to IDLE; cur_frame is kept so the frame is retried.
          gap_d = gap_q + 16'd1;
          if (gap_d == GAP_LIM) begin
            timeout_err_d = 1'b1;
            state_d       = S_IDLE;
          end else begin
            state_d = S_STREAM;
          end
        end
      end

      S_DONE: begin
        if (seek_valid) begin
          cur_frame_d = clamp_frame(seek_frame);
          state_d     = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    frame_num_iv_d = (state_d == S_ISSUE);
    frame_num_id_d = (state_d == S_ISSUE) ? cur_frame_q : frame_num_id_q;
    busy_d         = (state_d == S_ISSUE) || (state_d == S_STREAM);
    done_d         = (state_d == S_DONE);
  end

  assign frame_num_iv = frame_num_iv_q;
  assign frame_num_id = frame_num_id_q;
  assign cur_frame    = cur_frame_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign done         = done_q;
  assign timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Testbench for frame_sequencer: a vector table, directed multi-cycle scenarios and
// randomized stimulus, all checked against a frame-level reference model.
module tb_frame_sequencer;

  localparam int LAST_FRAME  = 124;
  localparam int FRAME_BYTES = 512;
  localparam int GAP_TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       play = 1'b0;
  logic       seek_valid = 1'b0;
  logic [6:0] seek_frame = 7'd0;
  logic       space_ok = 1'b0;
  logic       feed_v = 1'b0;
  logic       frame_num_iv;
  logic [6:0] frame_num_id;
  logic [6:0] cur_frame;
  logic       busy;
  logic       frame_done;
  logic       done;
  logic       timeout_err;

  always #5 clk = ~clk;

  frame_sequencer #(
    .LAST_FRAME (LAST_FRAME),
    .FRAME_BYTES(FRAME_BYTES),
    .GAP_TIMEOUT(GAP_TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .play        (play),
    .seek_valid  (seek_valid),
    .seek_frame  (seek_frame),
    .space_ok    (space_ok),
    .feed_v      (feed_v),
    .frame_num_iv(frame_num_iv),
    .frame_num_id(frame_num_id),
    .cur_frame   (cur_frame),
    .busy        (busy),
    .frame_done  (frame_done),
    .done        (done),
    .timeout_err (timeout_err)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: what the player is doing, which frame it is on, bytes seen so far.
  localparam int M_IDLE = 0, M_WAIT = 1, M_ISSUE = 2, M_STREAM = 3, M_DONE = 4;
  int m_mode = M_IDLE, m_cur = 0, m_id = 0, m_bytes = 0, m_gap = 0;
  bit m_iv = 1'b0, m_fdone = 1'b0, m_terr = 1'b0;

  int ids[$];
  int fdone_count = 0;

  typedef struct {
    bit         r, p, sv;
    logic [6:0] sf;
    bit         sp, fv;
    logic [18:0] exp;
  } vec_t;
  vec_t tbl[14];

  function automatic logic [18:0] pack(bit iv, int id, int cur, bit bsy, bit fd, bit dn, bit te);
    return {iv, 7'(id), 7'(cur), bsy, fd, dn, te};
  endfunction

  function automatic vec_t vec(bit r, bit p, bit sv, int sf, bit sp, bit fv, logic [18:0] e);
    vec_t v;
    v.r = r; v.p = p; v.sv = sv; v.sf = 7'(sf); v.sp = sp; v.fv = fv; v.exp = e;
    return v;
  endfunction

  function automatic int clamp(int f);
    return (f > LAST_FRAME) ? LAST_FRAME : f;
  endfunction

  task automatic check(string name, logic [18:0] act, logic [18:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @%0t: got iv=%0b id=%0d cur=%0d busy=%0b fdone=%0b done=%0b terr=%0b, expected iv=%0b id=%0d cur=%0d busy=%0b fdone=%0b done=%0b terr=%0b",
                  name, $time, act[18], act[17:11], act[10:4], act[3], act[2], act[1], act[0],
                  exp[18], exp[17:11], exp[10:4], exp[3], exp[2], exp[1], exp[0]);
  endtask

  task automatic chk_int(string name, int act, int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
  endtask

  task automatic model_step();
    m_iv = 1'b0;
    m_fdone = 1'b0;
    if (rst) begin
      m_mode = M_IDLE; m_cur = 0; m_id = 0; m_bytes = 0; m_gap = 0; m_terr = 1'b0;
    end else if (m_mode == M_IDLE) begin
      if (seek_valid) m_cur = clamp(int'(seek_frame));
      if (play) m_mode = M_WAIT;
    end else if (m_mode == M_WAIT) begin
      if (seek_valid) m_cur = clamp(int'(seek_frame));
      if (!play) m_mode = M_IDLE;
      else if (!seek_valid && space_ok) begin
        m_mode = M_ISSUE; m_iv = 1'b1; m_id = m_cur;
      end
    end else if (m_mode == M_ISSUE) begin
      m_mode = M_STREAM; m_bytes = 0; m_gap = 0;
    end else if (m_mode == M_STREAM) begin
      if (feed_v) begin
        m_bytes++;
        m_gap = 0;
        if (m_bytes == FRAME_BYTES) begin
          m_fdone = 1'b1;
          if (m_cur < LAST_FRAME) begin
            m_cur++;
            m_mode = play ? M_WAIT : M_IDLE;
          end else begin
`ifdef FRAME_SEQ_LOOP_EN
            m_cur = 0;
            m_mode = play ? M_WAIT : M_IDLE;
`else
            m_mode = M_DONE;
`endif
          end
        end
      end else begin
        m_gap++;
        if (m_gap >= GAP_TIMEOUT) begin
          m_terr = 1'b1; m_mode = M_IDLE;
        end
      end
    end else if (m_mode == M_DONE) begin
      if (seek_valid) begin
        m_cur = clamp(int'(seek_frame)); m_mode = M_IDLE;
      end
    end
  endtask

  function automatic logic [18:0] model_out();
    return pack(m_iv, m_id, m_cur, (m_mode == M_ISSUE) || (m_mode == M_STREAM),
                m_fdone, m_mode == M_DONE, m_terr);
  endfunction

  function automatic logic [18:0] dut_out();
    return {frame_num_iv, frame_num_id, cur_frame, busy, frame_done, done, timeout_err};
  endfunction

  task automatic drive(bit r, bit p, bit sv, int sf, bit sp, bit fv);
    rst = r; play = p; seek_valid = sv; seek_frame = 7'(sf); space_ok = sp; feed_v = fv;
  endtask

  task automatic tick(string name, bit cmp);
    @(posedge clk);
    #1;
    model_step();
    if (frame_num_iv) ids.push_back(int'(frame_num_id));
    if (frame_done) fdone_count++;
    if (cmp) check(name, dut_out(), model_out());
  endtask

  task automatic reset_dut();
    drive(1, 0, 0, 0, 0, 0);
    tick("reset", 1);
    drive(0, 0, 0, 0, 0, 0);
    ids.delete();
    fdone_count = 0;
  endtask

  int id_a, id_b;

  initial begin
    // Table: {rst, play, seek_valid, seek_frame, space_ok, feed_v} -> outputs after the edge.
    tbl[0]  = vec(1, 0, 0,   0, 0, 0, pack(0, 0,   0, 0, 0, 0, 0));
    tbl[1]  = vec(0, 0, 1, 127, 0, 0, pack(0, 0, 124, 0, 0, 0, 0));
    tbl[2]  = vec(0, 0, 1,   5, 0, 0, pack(0, 0,   5, 0, 0, 0, 0));
    tbl[3]  = vec(0, 1, 0,   0, 0, 0, pack(0, 0,   5, 0, 0, 0, 0));
    tbl[4]  = vec(0, 1, 1,   9, 1, 0, pack(0, 0,   9, 0, 0, 0, 0));
    tbl[5]  = vec(0, 1, 0,   0, 1, 0, pack(1, 9,   9, 1, 0, 0, 0));
    tbl[6]  = vec(0, 1, 1,   3, 1, 1, pack(0, 9,   9, 1, 0, 0, 0));
    tbl[7]  = vec(0, 0, 1,   2, 0, 1, pack(0, 9,   9, 1, 0, 0, 0));
    tbl[8]  = vec(1, 0, 0,   0, 0, 1, pack(0, 0,   0, 0, 0, 0, 0));
    tbl[9]  = vec(0, 0, 0,   0, 0, 1, pack(0, 0,   0, 0, 0, 0, 0));
    tbl[10] = vec(0, 1, 0,   0, 0, 0, pack(0, 0,   0, 0, 0, 0, 0));
    tbl[11] = vec(0, 0, 0,   0, 1, 0, pack(0, 0,   0, 0, 0, 0, 0));
    tbl[12] = vec(0, 1, 0,   0, 1, 0, pack(0, 0,   0, 0, 0, 0, 0));
    tbl[13] = vec(0, 1, 0,   0, 1, 0, pack(1, 0,   0, 1, 0, 0, 0));

    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].r, tbl[i].p, tbl[i].sv, int'(tbl[i].sf), tbl[i].sp, tbl[i].fv);
      tick("table", 0);
      check($sformatf("table_row%0d", i), dut_out(), tbl[i].exp);
    end

    // One full frame with bytes 19 cycles apart, then the next request.
    reset_dut();
    drive(0, 1, 0, 0, 1, 0);
    tick("slow_wait", 1);
    tick("slow_issue", 1);
    for (int i = 0; i < FRAME_BYTES; i++) begin
      drive(0, 1, 0, 0, 1, 0);
      repeat (18) tick("slow_gap", 1);
      drive(0, 1, 0, 0, 1, 1);
      tick("slow_byte", 1);
    end
    drive(0, 1, 0, 0, 1, 0);
    repeat (4) tick("slow_next", 1);
    id_a = (ids.size() > 0) ? ids[0] : -1;
    id_b = (ids.size() > 1) ? ids[1] : -1;
    chk_int("slow_req_count", ids.size(), 2);
    chk_int("slow_first_id", id_a, 0);
    chk_int("slow_second_id", id_b, 1);
    chk_int("slow_frame_done_count", fdone_count, 1);

    // Last frame: stop in DONE, or wrap to frame 0 when looping.
    reset_dut();
    drive(0, 0, 1, 124, 0, 0);
    tick("last_seek", 1);
    drive(0, 1, 0, 0, 1, 0);
    tick("last_wait", 1);
    tick("last_issue", 1);
    tick("last_enter", 1);
    drive(0, 1, 0, 0, 1, 1);
    repeat (FRAME_BYTES) tick("last_byte", 1);
    drive(0, 1, 0, 0, 1, 0);
    repeat (3) tick("last_after", 1);
`ifdef FRAME_SEQ_LOOP_EN
    id_b = (ids.size() > 1) ? ids[1] : -1;
    chk_int("loop_req_count", ids.size(), 2);
    chk_int("loop_wrap_id", id_b, 0);
`else
    chk_int("last_done", int'(done), 1);
    chk_int("last_cur", int'(cur_frame), 124);
    chk_int("last_req_count", ids.size(), 1);
    drive(0, 1, 1, 3, 1, 0);
    tick("done_seek", 1);
    chk_int("done_seek_cur", int'(cur_frame), 3);
    chk_int("done_seek_done", int'(done), 0);
`endif

    // Feeder stalls after 100 bytes.
    reset_dut();
    drive(0, 0, 1, 7, 0, 0);
    tick("to_seek", 1);
    drive(0, 1, 0, 0, 1, 0);
    tick("to_wait", 1);
    tick("to_issue", 1);
    tick("to_enter", 1);
    drive(0, 1, 0, 0, 1, 1);
    repeat (100) tick("to_byte", 1);
    drive(0, 1, 0, 0, 1, 0);
    repeat (GAP_TIMEOUT - 1) tick("to_gap", 1);
    chk_int("to_not_yet", int'(timeout_err), 0);
    tick("to_fire", 1);
    chk_int("to_flag", int'(timeout_err), 1);
    chk_int("to_idle", int'(busy), 0);
    repeat (3) tick("to_retry", 1);
    id_b = (ids.size() > 1) ? ids[1] : -1;
    chk_int("to_retry_id", id_b, 7);
    chk_int("to_sticky", int'(timeout_err), 1);

    // No space for 200 cycles, then space.
    reset_dut();
    drive(0, 1, 0, 0, 0, 0);
    repeat (200) tick("space_hold", 1);
    chk_int("space_no_req", ids.size(), 0);
    drive(0, 1, 0, 0, 1, 0);
    tick("space_rise", 1);
    chk_int("space_req", int'(frame_num_iv), 1);

    // Pause mid-frame: the frame completes, then IDLE.
    reset_dut();
    drive(0, 0, 1, 10, 0, 0);
    tick("pause_seek", 1);
    drive(0, 1, 0, 0, 1, 0);
    tick("pause_wait", 1);
    tick("pause_issue", 1);
    tick("pause_enter", 1);
    drive(0, 1, 0, 0, 1, 1);
    repeat (300) tick("pause_byte", 1);
    drive(0, 0, 0, 0, 1, 1);
    repeat (FRAME_BYTES - 300) tick("pause_rest", 1);
    chk_int("pause_done_pulse", fdone_count, 1);
    chk_int("pause_cur", int'(cur_frame), 11);
    chk_int("pause_idle", int'(busy), 0);
    drive(0, 0, 0, 0, 1, 0);
    repeat (5) tick("pause_hold", 1);
    chk_int("pause_no_req", ids.size(), 1);

    // Reset one byte before the frame ends.
    reset_dut();
    drive(0, 1, 0, 0, 1, 0);
    tick("rst_wait", 1);
    tick("rst_issue", 1);
    tick("rst_enter", 1);
    drive(0, 1, 0, 0, 1, 1);
    repeat (FRAME_BYTES - 1) tick("rst_byte", 1);
    drive(1, 1, 0, 0, 1, 1);
    tick("rst_mid", 1);
    drive(0, 0, 0, 0, 0, 1);
    tick("rst_after", 1);
    chk_int("rst_no_frame_done", fdone_count, 0);

    // Randomized segments with different feeder densities.
    for (int seg = 0; seg < 4; seg++) begin
      int pct;
      pct = (seg == 0) ? 90 : (seg == 1) ? 50 : (seg == 2) ? 2 : 98;
      reset_dut();
      for (int c = 0; c < 2000; c++) begin
        drive($urandom_range(0, 1999) == 0,
              $urandom_range(0, 99) < 85,
              $urandom_range(0, 31) == 0,
              int'($urandom_range(0, 127)),
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 99) < pct);
        tick($sformatf("random_seg%0d", seg), 1);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
